// File: rtl/alu_arbiter.sv
// Two-port round-robin arbiter in front of a shared combinational RV32I ALU.
// Define ALU_ARB_FIXED_PRIO_EN to give port 0 fixed priority on a tie.
module alu_arbiter #(
    parameter int XLEN = 32,
    parameter int OPW  = 17,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      req_valid,
    output logic [1:0]      req_ready,
    input  logic [XLEN-1:0] req_a0,
    input  logic [XLEN-1:0] req_b0,
    input  logic [OPW-1:0]  req_op0,
    input  logic [XLEN-1:0] req_a1,
    input  logic [XLEN-1:0] req_b1,
    input  logic [OPW-1:0]  req_op1,
    output logic [1:0]      rsp_valid,
    input  logic [1:0]      rsp_ready,
    output logic [XLEN-1:0] rsp_y,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [OPW-1:0]  alu_op,
    input  logic [XLEN-1:0] alu_y,
    output logic            busy,
    output logic [CNTW-1:0] gnt_cnt0,
    output logic [CNTW-1:0] gnt_cnt1
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [CNTW-1:0] CNT_MAX = '1;

    logic [1:0]      state_q,   state_d;
    logic            rr_last_q, rr_last_d;
    logic            owner_q,   owner_d;
    logic [XLEN-1:0] a_q,       a_d;
    logic [XLEN-1:0] b_q,       b_d;
    logic [OPW-1:0]  op_q,      op_d;
    logic [XLEN-1:0] y_q,       y_d;
    logic [CNTW-1:0] cnt0_q,    cnt0_d;
    logic [CNTW-1:0] cnt1_q,    cnt1_d;

    logic grant;
    logic accept;

    // Grant is the port that would be accepted this cycle if IDLE.
    always_comb begin
        grant = 1'b0;
        if (req_valid == 2'b11) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            grant = 1'b0;
`else
            grant = ~rr_last_q;
`endif
        end else if (req_valid[1]) begin
            grant = 1'b1;
        end
    end

    // Valid/ready: a request transfers on a cycle where req_valid[n] and
    // req_ready[n] are both high; a response transfers on rsp_valid[n] and
    // rsp_ready[n]. Ready never depends on anything but valid and state.
    always_comb begin
        req_ready = 2'b00;
        if (state_q == ST_IDLE && !rst) begin
            req_ready = grant ? {req_valid[1], 1'b0} : {1'b0, req_valid[0]};
        end
    end

    assign accept = |req_ready;

    always_comb begin
        state_d   = state_q;
        rr_last_d = rr_last_q;
        owner_d   = owner_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        y_d       = y_q;
        cnt0_d    = cnt0_q;
        cnt1_d    = cnt1_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    owner_d   = grant;
                    rr_last_d = grant;
                    a_d       = grant ? req_a1  : req_a0;
                    b_d       = grant ? req_b1  : req_b0;
                    op_d      = grant ? req_op1 : req_op0;
                    if (!grant && cnt0_q != CNT_MAX) begin
                        cnt0_d = cnt0_q + 1'b1;
                    end
                    if (grant && cnt1_q != CNT_MAX) begin
                        cnt1_d = cnt1_q + 1'b1;
                    end
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                y_d     = alu_y;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready[owner_q]) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Reset drops any in-flight operation; rr_last=1 lets port 0 win the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            rr_last_q <= 1'b1;
            owner_q   <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            y_q       <= '0;
            cnt0_q    <= '0;
            cnt1_q    <= '0;
        end else begin
            state_q   <= state_d;
            rr_last_q <= rr_last_d;
            owner_q   <= owner_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            y_q       <= y_d;
            cnt0_q    <= cnt0_d;
            cnt1_q    <= cnt1_d;
        end
    end

    assign rsp_valid = (state_q == ST_RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_y     = y_q;
    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign alu_op    = op_q;
    assign busy      = (state_q != ST_IDLE);
    assign gnt_cnt0  = cnt0_q;
    assign gnt_cnt1  = cnt1_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a default-width instance plus a CNTW=2
// instance for counter saturation; responses are matched against exp_q.
module tb_alu_arbiter;

  localparam int XLEN = 32;
  localparam int OPW  = 17;

  localparam logic [16:0] OP_ADD  = 17'h00033;
  localparam logic [16:0] OP_SUB  = 17'h08033;
  localparam logic [16:0] OP_ADDI = 17'h00013;
  localparam logic [16:0] OP_XOR  = 17'h00233;  // funct3=4 in bits [9:7]

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- main DUT ----------------
  logic [1:0]      req_valid = 2'b00;
  logic [1:0]      req_ready;
  logic [XLEN-1:0] req_a0 = '0, req_b0 = '0, req_a1 = '0, req_b1 = '0;
  logic [OPW-1:0]  req_op0 = '0, req_op1 = '0;
  logic [1:0]      rsp_valid;
  logic [1:0]      rsp_ready = 2'b11;
  logic [XLEN-1:0] rsp_y, alu_a, alu_b, alu_y;
  logic [OPW-1:0]  alu_op;
  logic            busy;
  logic [15:0]     gnt_cnt0, gnt_cnt1;

  alu_arbiter dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_b0(req_b0), .req_op0(req_op0),
    .req_a1(req_a1), .req_b1(req_b1), .req_op1(req_op1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_y(alu_y),
    .busy(busy), .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
  );

  // ---------------- saturation DUT (CNTW=2) ----------------
  logic [1:0]      s_req_valid = 2'b00;
  logic [1:0]      s_req_ready;
  logic [XLEN-1:0] s_req_a0 = '0, s_req_b0 = '0;
  logic [XLEN-1:0] s_zero = '0;
  logic [OPW-1:0]  s_req_op0 = '0, s_op_zero = '0;
  logic [1:0]      s_rsp_valid;
  logic [1:0]      s_rsp_ready = 2'b11;
  logic [XLEN-1:0] s_rsp_y, s_alu_a, s_alu_b, s_alu_y;
  logic [OPW-1:0]  s_alu_op;
  logic            s_busy;
  logic [1:0]      s_cnt0, s_cnt1;

  alu_arbiter #(.CNTW(2)) dut_sat (
    .clk(clk), .rst(rst),
    .req_valid(s_req_valid), .req_ready(s_req_ready),
    .req_a0(s_req_a0), .req_b0(s_req_b0), .req_op0(s_req_op0),
    .req_a1(s_zero), .req_b1(s_zero), .req_op1(s_op_zero),
    .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready), .rsp_y(s_rsp_y),
    .alu_a(s_alu_a), .alu_b(s_alu_b), .alu_op(s_alu_op), .alu_y(s_alu_y),
    .busy(s_busy), .gnt_cnt0(s_cnt0), .gnt_cnt1(s_cnt1)
  );

  // ---------------- ALU behavioural model ----------------
  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [16:0] op);
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    opc = op[6:0];
    f3  = op[9:7];
    f7  = op[16:10];
    alu_f = '0;
    if (opc == 7'h33 || opc == 7'h13) begin
      case (f3)
        3'd0: alu_f = (opc == 7'h33 && f7[5]) ? a - b : a + b;
        3'd1: alu_f = a << b[4:0];
        3'd2: alu_f = {31'b0, $signed(a) < $signed(b)};
        3'd3: alu_f = {31'b0, a < b};
        3'd4: alu_f = a ^ b;
        3'd5: alu_f = f7[5] ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
        3'd6: alu_f = a | b;
        default: alu_f = a & b;
      endcase
    end
  endfunction

  assign alu_y   = alu_f(alu_a, alu_b, alu_op);
  assign s_alu_y = alu_f(s_alu_a, s_alu_b, s_alu_op);

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [32:0] exp_q[$];   // {port, y}
  logic [32:0] mon_e;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] oh(input int p);
    return (p == 0) ? 2'b01 : 2'b10;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      for (int p = 0; p < 2; p++) begin
        if (rsp_valid[p] && rsp_ready[p]) begin
          if (exp_q.size() == 0) begin
            chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
          end else begin
            mon_e = exp_q.pop_front();
            chk("rsp_port", 64'(p), 64'(mon_e[32]));
            chk("rsp_y", 64'(rsp_y), 64'(mon_e[31:0]));
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input logic [31:0] a, input logic [31:0] b,
                         input logic [16:0] op);
    if (p == 0) begin
      req_a0 = a; req_b0 = b; req_op0 = op;
    end else begin
      req_a1 = a; req_b1 = b; req_op1 = op;
    end
  endtask

  // Single uncontended op with exact-latency checks; starts and ends at posedge+1.
  task automatic send(input int p, input logic [31:0] a, input logic [31:0] b,
                      input logic [16:0] op, input logic [31:0] y);
    exp_q.push_back({p[0], y});
    set_req(p, a, b, op);
    req_valid[p] = 1'b1;
    @(negedge clk);
    chk("send_ready", 64'(req_ready), 64'(oh(p)));
    step();
    req_valid[p] = 1'b0;
    @(negedge clk);
    chk("exec_busy", 64'(busy), 64'd1);
    chk("exec_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("exec_alu_a", 64'(alu_a), 64'(a));
    chk("exec_alu_b", 64'(alu_b), 64'(b));
    chk("exec_alu_op", 64'(alu_op), 64'(op));
    @(negedge clk);
    chk("resp_valid", 64'(rsp_valid), 64'(oh(p)));
    chk("resp_y", 64'(rsp_y), 64'(y));
    step();
    chk("idle_busy", 64'(busy), 64'd0);
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    while (busy && c < 20) begin
      step();
      c++;
    end
    chk("idle_timeout", 64'(busy), 64'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int grants;
    int c;
    logic [1:0] g_exp;
    logic [15:0] c1_before;

    // Reset: ready must stay low even with both ports valid.
    req_valid = 2'b11;
    #2;
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_y", 64'(rsp_y), 64'd0);
    chk("rst_alu_a", 64'(alu_a), 64'd0);
    chk("rst_alu_b", 64'(alu_b), 64'd0);
    chk("rst_alu_op", 64'(alu_op), 64'd0);
    chk("rst_cnt0", 64'(gnt_cnt0), 64'd0);
    chk("rst_cnt1", 64'(gnt_cnt1), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    req_valid = 2'b00;
    step();
    rst = 1'b0;
    step();

    // Single add on port 0, then sub on port 1.
    send(0, 32'd5, 32'd7, OP_ADD, 32'd12);
    chk("add_cnt0", 64'(gnt_cnt0), 64'd1);
    send(1, 32'd3, 32'd5, OP_SUB, 32'hFFFF_FFFE);
    chk("sub_cnt1", 64'(gnt_cnt1), 64'd1);

    // Contention: both ports hold valid for four grants.
    set_req(0, 32'd1, 32'd1, OP_ADDI);
    set_req(1, 32'h0000_00F0, 32'h0000_00FF, OP_XOR);
    c1_before = gnt_cnt1;
    for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      exp_q.push_back({1'b0, 32'd2});
`else
      exp_q.push_back((i % 2 == 0) ? {1'b0, 32'd2} : {1'b1, 32'h0000_000F});
`endif
    end
    req_valid = 2'b11;
    grants = 0;
    c = 0;
    while (grants < 4 && c < 40) begin
      @(negedge clk);
      if (req_ready != 2'b00) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
        g_exp = 2'b01;
`else
        g_exp = (grants % 2 == 0) ? 2'b01 : 2'b10;
`endif
        chk("tie_grant", 64'(req_ready), 64'(g_exp));
        grants++;
      end
      c++;
    end
    chk("tie_grant_count", 64'(grants), 64'd4);
    step();
    req_valid = 2'b00;
    wait_idle();
`ifdef ALU_ARB_FIXED_PRIO_EN
    chk("tie_cnt0", 64'(gnt_cnt0), 64'd5);
    chk("tie_cnt1", 64'(gnt_cnt1), 64'(c1_before));
`else
    chk("tie_cnt0", 64'(gnt_cnt0), 64'd3);
    chk("tie_cnt1", 64'(gnt_cnt1), 64'd3);
`endif

    // Backpressure: port 0 response held for 5 cycles while port 1 waits.
    rsp_ready = 2'b10;
    exp_q.push_back({1'b0, 32'd30});
    set_req(0, 32'd10, 32'd20, OP_ADD);
    req_valid = 2'b01;
    step();
    req_valid = 2'b00;
    exp_q.push_back({1'b1, 32'd5});
    set_req(1, 32'd9, 32'd4, OP_SUB);
    req_valid = 2'b10;
    @(negedge clk);
    chk("bp_exec_ready", 64'(req_ready), 64'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("bp_rsp_y", 64'(rsp_y), 64'd30);
      chk("bp_req_ready", 64'(req_ready), 64'd0);
    end
    step();
    rsp_ready = 2'b11;
    @(negedge clk);
    chk("bp_release_valid", 64'(rsp_valid), 64'd1);
    step();
    @(negedge clk);
    chk("bp_next_grant", 64'(req_ready), 64'd2);
    step();
    req_valid = 2'b00;
    wait_idle();

    // Reset during EXEC of a port 0 op: the op must vanish.
    set_req(0, 32'd77, 32'd1, OP_ADD);
    req_valid = 2'b01;
    step();
    chk("mid_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    req_valid = 2'b00;
    #1;
    chk("mid_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("mid_busy_rst", 64'(busy), 64'd0);
    chk("mid_cnt0", 64'(gnt_cnt0), 64'd0);
    chk("mid_cnt1", 64'(gnt_cnt1), 64'd0);
    chk("mid_rsp_y", 64'(rsp_y), 64'd0);
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("mid_no_rsp", 64'(rsp_valid), 64'd0);
    end
    step();

    // First tie after reset goes to port 0, then port 1.
    exp_q.push_back({1'b0, 32'd123});
    exp_q.push_back({1'b1, 32'd42});
    set_req(0, 32'd100, 32'd23, OP_ADD);
    set_req(1, 32'd50, 32'd8, OP_SUB);
    req_valid = 2'b11;
    @(negedge clk);
    chk("post_rst_tie", 64'(req_ready), 64'd1);
    step();
    req_valid = 2'b10;
    c = 0;
    while (!req_ready[1] && c < 20) begin
      @(negedge clk);
      c++;
    end
    chk("post_rst_p1_grant", 64'(req_ready), 64'd2);
    step();
    req_valid = 2'b00;
    wait_idle();
    chk("post_rst_cnt0", 64'(gnt_cnt0), 64'd1);
    chk("post_rst_cnt1", 64'(gnt_cnt1), 64'd1);

    // Counter saturation on the CNTW=2 instance.
    for (int i = 0; i < 5; i++) begin
      s_req_a0 = 32'(i);
      s_req_b0 = 32'd1;
      s_req_op0 = OP_ADD;
      s_req_valid = 2'b01;
      step();
      s_req_valid = 2'b00;
      @(negedge clk);
      @(negedge clk);
      chk("sat_rsp_valid", 64'(s_rsp_valid), 64'd1);
      chk("sat_rsp_y", 64'(s_rsp_y), 64'(i + 1));
      step();
      chk("sat_cnt0", 64'(s_cnt0), (i + 1 > 3) ? 64'd3 : 64'(i + 1));
    end
    chk("sat_cnt1", 64'(s_cnt1), 64'd0);

    repeat (3) step();
    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sequence did not finish, got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
